// File: rtl/mux_rr_buffered.sv
// N:1 round-robin time-division multiplexer. Every input lane has its own FIFO.
// Non-empty lanes are drained onto a single registered output stream, tagged with the source lane.
module mux_rr_buffered #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] dataIn,
  input  logic [CHANNELS-1:0]       validIn,
  output logic [CHANNELS-1:0]       full,
  output logic [CHANNELS-1:0]       overflow,
  output logic [WIDTH-1:0]          dataOut,
  output logic [SEL_W-1:0]          chanOut,
  output logic                      validOut,
  input  logic                      readyOut
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem       [CHANNELS][DEPTH];
  logic [PTR_W-1:0]    wrPtr     [CHANNELS];
  logic [PTR_W-1:0]    rdPtr     [CHANNELS];
  logic [CNT_W-1:0]    count     [CHANNELS];
  logic [CNT_W-1:0]    nextCount [CHANNELS];
  logic [CHANNELS-1:0] notEmpty;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    grant;
  logic                grantValid;
  logic                load;
  int                  scanIdx;

  assign load = !validOut || readyOut;

  // A write into a full lane is dropped even when that lane pops in the
  // same cycle, because full reflects the count at the start of the cycle.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      notEmpty[i]  = (count[i] != '0);
      push[i]      = validIn[i] && !full[i];
      pop[i]       = load && grantValid && (grant == SEL_W'(i));
      nextCount[i] = count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  // NOTE: every variable written in always_comb gets a default before any
  // conditional assignment; otherwise the missing path infers a latch.
  always_comb begin
    grantValid = 1'b0;
    grant      = ptr;
    scanIdx    = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      scanIdx = (int'(ptr) + k) % CHANNELS;
      if (!grantValid && notEmpty[scanIdx]) begin
        grantValid = 1'b1;
        grant      = SEL_W'(scanIdx);
      end
    end
  end

  // NOTE: sequential state is assigned with <= so that every register
  // samples the values from before the edge, no matter how statements are ordered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wrPtr[i] <= '0;
        rdPtr[i] <= '0;
        count[i] <= '0;
      end
      full     <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (push[i]) wrPtr[i] <= wrPtr[i] + PTR_W'(1);
        if (pop[i])  rdPtr[i] <= rdPtr[i] + PTR_W'(1);
        count[i]    <= nextCount[i];
        full[i]     <= (nextCount[i] == CNT_W'(DEPTH));
        overflow[i] <= validIn[i] && full[i];
      end
    end
  end

  // NOTE: the storage array has no reset. Its contents are only ever read
  // behind a non-zero count, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (push[i]) mem[i][wrPtr[i]] <= dataIn[i*WIDTH +: WIDTH];
    end
  end

  // Registered output stage. dataOut and chanOut keep their last value when no lane is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validOut <= 1'b0;
      dataOut  <= '0;
      chanOut  <= '0;
      ptr      <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      validOut <= grantValid;
      if (grantValid) begin
        dataOut <= mem[grant][rdPtr[grant]];
        chanOut <= grant;
        ptr     <= grant;
      end
    end
  end

endmodule
